// File: rtl/tm_pkg.sv
// Shared types and default widths for the class-sum voting datapath.
// Used by the per-class accumulator/argmax and the single-channel clamp path.
package tm_pkg;

  localparam int DEF_SUM_W     = 32;
  localparam int DEF_VOTE_W    = 8;
  localparam int DEF_THRESHOLD = 50;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    ARGMAX = 2'd2,
    DONE   = 2'd3
  } state_t;

  typedef logic signed [DEF_SUM_W-1:0] sum_t;

endpackage

// File: rtl/tm_sat_clamp_add.sv
// Combinational signed sum + vote, clamped to [-THRESHOLD, +THRESHOLD].
// Zero latency; no handshake. The add has one guard bit so it cannot wrap.
module tm_sat_clamp_add #(
  parameter int SUM_W     = 32,
  parameter int VOTE_W    = 8,
  parameter int THRESHOLD = 50
) (
  input  logic signed [SUM_W-1:0]  sum_in,
  input  logic signed [VOTE_W-1:0] vote,
  output logic signed [SUM_W-1:0]  sum_out
);

  localparam logic signed [SUM_W:0] T_POS = (SUM_W+1)'(THRESHOLD);
  localparam logic signed [SUM_W:0] T_NEG = -T_POS;

  logic signed [SUM_W:0] wide;

  always_comb begin
    wide = {sum_in[SUM_W-1], sum_in} + {{(SUM_W+1-VOTE_W){vote[VOTE_W-1]}}, vote};
    if (wide > T_POS) begin
      sum_out = T_POS[SUM_W-1:0];
    end else if (wide < T_NEG) begin
      sum_out = T_NEG[SUM_W-1:0];
    end else begin
      sum_out = wide[SUM_W-1:0];
    end
  end

endmodule

// File: rtl/class_sum_accum_argmax.sv
// Per-class clamped vote accumulator followed by a one-class-per-cycle argmax.
// pred_valid rises N_CLASSES+1 cycles after the last vote; held until pred_ready; stop_flag freezes all.
module class_sum_accum_argmax
  import tm_pkg::*;
#(
  parameter int N_CLASSES = 4,
  parameter int SUM_W     = DEF_SUM_W,
  parameter int VOTE_W    = DEF_VOTE_W,
  parameter int THRESHOLD = DEF_THRESHOLD,
  localparam int IDX_W    = $clog2(N_CLASSES)
) (
  input  logic                       clk,
  input  logic                       rst_flag,
  input  logic                       stop_flag,
  input  logic                       start,
  input  logic                       vote_valid,
  output logic                       vote_ready,
  input  logic [IDX_W-1:0]           vote_class,
  input  logic signed [VOTE_W-1:0]   vote_in,
  input  logic                       vote_last,
  output logic [N_CLASSES*SUM_W-1:0] class_sum_out,
  output logic                       pred_valid,
  input  logic                       pred_ready,
  output logic [IDX_W-1:0]           pred_class,
  output logic signed [SUM_W-1:0]    pred_sum,
  output logic                       busy
);

  localparam longint T_MAX = (64'sd1 <<< (SUM_W-1)) - (64'sd1 <<< (VOTE_W-1));

  if (N_CLASSES < 2 || THRESHOLD <= 0 || longint'(THRESHOLD) > T_MAX) begin : g_bad_params
    $error("class_sum_accum_argmax: illegal N_CLASSES/THRESHOLD for the chosen widths");
  end

  state_t state, state_nxt;

  logic signed [SUM_W-1:0] sums [N_CLASSES];
  logic [IDX_W-1:0]        scan_idx;
  logic signed [SUM_W-1:0] best_val;
  logic [IDX_W-1:0]        best_idx;

  logic                    vote_acc;
  logic                    scan_last;
  logic                    cand_better;
  logic signed [SUM_W-1:0] sel_sum;
  logic signed [SUM_W-1:0] upd_sum;
  logic signed [SUM_W-1:0] scan_val;
  logic signed [SUM_W-1:0] nxt_best_val;
  logic [IDX_W-1:0]        nxt_best_idx;

  assign vote_ready = (state == ACCUM) && !stop_flag && !start;
  assign vote_acc   = vote_valid && vote_ready;
  assign scan_last  = (scan_idx == IDX_W'(N_CLASSES-1));
  assign busy       = (state == ACCUM) || (state == ARGMAX);

  // Out-of-range class indices match no entry, so they read zero and write nothing.
  always_comb begin
    sel_sum  = '0;
    scan_val = '0;
    for (int k = 0; k < N_CLASSES; k++) begin
      if (vote_class == IDX_W'(k)) sel_sum = sums[k];
      if (scan_idx == IDX_W'(k))   scan_val = sums[k];
      class_sum_out[k*SUM_W +: SUM_W] = sums[k];
    end
  end

  tm_sat_clamp_add #(
    .SUM_W     (SUM_W),
    .VOTE_W    (VOTE_W),
    .THRESHOLD (THRESHOLD)
  ) u_clamp_add (
    .sum_in  (sel_sum),
    .vote    (vote_in),
    .sum_out (upd_sum)
  );

  // Index 0 always seeds; later classes win only when strictly greater.
  always_comb begin
    cand_better  = (scan_idx == '0) || (scan_val > best_val);
    nxt_best_val = cand_better ? scan_val : best_val;
    nxt_best_idx = cand_better ? scan_idx : best_idx;
  end

  always_comb begin
    state_nxt = state;
    if (!stop_flag) begin
      if (start) begin
        state_nxt = ACCUM;
      end else begin
        case (state)
          ACCUM:   if (vote_acc && vote_last) state_nxt = ARGMAX;
          ARGMAX:  if (scan_last) state_nxt = DONE;
          DONE:    if (pred_ready) state_nxt = IDLE;
          default: state_nxt = state;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst_flag) begin
    if (rst_flag) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst_flag) begin
    if (rst_flag) begin
      for (int k = 0; k < N_CLASSES; k++) sums[k] <= '0;
      scan_idx   <= '0;
      best_val   <= '0;
      best_idx   <= '0;
      pred_valid <= 1'b0;
      pred_class <= '0;
      pred_sum   <= '0;
    end else if (!stop_flag) begin
      if (start) begin
        for (int k = 0; k < N_CLASSES; k++) sums[k] <= '0;
        scan_idx   <= '0;
        pred_valid <= 1'b0;
      end else begin
        case (state)
          ACCUM: begin
            scan_idx <= '0;
            for (int k = 0; k < N_CLASSES; k++) begin
              if (vote_acc && vote_class == IDX_W'(k)) sums[k] <= upd_sum;
            end
          end
          ARGMAX: begin
            best_val <= nxt_best_val;
            best_idx <= nxt_best_idx;
            scan_idx <= scan_idx + IDX_W'(1);
            if (scan_last) begin
              scan_idx   <= '0;
              pred_class <= nxt_best_idx;
              pred_sum   <= nxt_best_val;
              pred_valid <= 1'b1;
            end
          end
          DONE: begin
            if (pred_ready) pred_valid <= 1'b0;
          end
          default: begin
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_class_sum_accum_argmax.sv
// Directed bench for class_sum_accum_argmax built with 5 classes so an index >= N_CLASSES is drivable.
module tb_class_sum_accum_argmax;

  localparam int NC     = 5;
  localparam int SW     = 32;
  localparam int VW     = 8;
  localparam int IW     = 3;

  logic               clk = 1'b0;
  logic               rst_flag = 1'b1;
  logic               stop_flag = 1'b0;
  logic               start = 1'b0;
  logic               vote_valid = 1'b0;
  logic               vote_ready;
  logic [IW-1:0]      vote_class = '0;
  logic signed [VW-1:0] vote_in = '0;
  logic               vote_last = 1'b0;
  logic [NC*SW-1:0]   class_sum_out;
  logic               pred_valid;
  logic               pred_ready = 1'b0;
  logic [IW-1:0]      pred_class;
  logic signed [SW-1:0] pred_sum;
  logic               busy;

  int n_checks = 0;
  int n_errors = 0;

  class_sum_accum_argmax #(
    .N_CLASSES (NC),
    .SUM_W     (SW),
    .VOTE_W    (VW),
    .THRESHOLD (50)
  ) dut (
    .clk           (clk),
    .rst_flag      (rst_flag),
    .stop_flag     (stop_flag),
    .start         (start),
    .vote_valid    (vote_valid),
    .vote_ready    (vote_ready),
    .vote_class    (vote_class),
    .vote_in       (vote_in),
    .vote_last     (vote_last),
    .class_sum_out (class_sum_out),
    .pred_valid    (pred_valid),
    .pred_ready    (pred_ready),
    .pred_class    (pred_class),
    .pred_sum      (pred_sum),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic signed [SW-1:0] sum_of(input int k);
    return $signed(class_sum_out[k*SW +: SW]);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_vote(input int cls, input int val, input bit last);
    vote_valid = 1'b1;
    vote_class = IW'(cls);
    vote_in    = VW'(val);
    vote_last  = last;
    tick();
    vote_valid = 1'b0;
    vote_last  = 1'b0;
  endtask

  task automatic wait_pred(output int n);
    n = 0;
    while (!pred_valid && n < 40) begin
      tick();
      n++;
    end
  endtask

  task automatic check_sums(input string tag, input int e0, input int e1, input int e2, input int e3, input int e4);
    check({tag, "_c0"}, sum_of(0), e0);
    check({tag, "_c1"}, sum_of(1), e1);
    check({tag, "_c2"}, sum_of(2), e2);
    check({tag, "_c3"}, sum_of(3), e3);
    check({tag, "_c4"}, sum_of(4), e4);
  endtask

  initial begin
    int lat;

    // Reset values
    #3;
    check("rst_pred_valid", pred_valid, 0);
    check("rst_vote_ready", vote_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_sums_zero", |class_sum_out, 0);
    check("rst_pred_class", pred_class, 0);
    check("rst_pred_sum", pred_sum, 0);
    tick();
    rst_flag = 1'b0;
    tick();

    // IDLE ignores votes
    vote_valid = 1'b1; vote_class = 3'd0; vote_in = 8'sd9;
    #1;
    check("idle_vote_ready", vote_ready, 0);
    tick();
    vote_valid = 1'b0;
    check("idle_sums_zero", |class_sum_out, 0);

    // Basic inference; vote coincident with start is refused
    start = 1'b1; vote_valid = 1'b1; vote_class = 3'd0; vote_in = 8'sd5;
    #1;
    check("start_vote_ready", vote_ready, 0);
    tick();
    start = 1'b0; vote_valid = 1'b0;
    check("basic_busy", busy, 1);
    check("basic_sum0_init", sum_of(0), 0);
    send_vote(0, 3, 0);
    check("basic_first_visible", sum_of(0), 3);
    send_vote(1, 7, 0);
    send_vote(2, -4, 0);
    send_vote(1, 2, 1);
    check_sums("basic", 3, 9, -4, 0, 0);
    check("basic_argmax_busy", busy, 1);
    wait_pred(lat);
    check("basic_latency", lat, NC);
    check("basic_pred_class", pred_class, 1);
    check("basic_pred_sum", pred_sum, 9);
    check("basic_done_busy", busy, 0);
    pred_ready = 1'b1;
    tick();
    pred_ready = 1'b0;
    check("basic_consumed", pred_valid, 0);
    check("basic_sum_hold", sum_of(1), 9);

    // Saturation at both rails
    do_start();
    for (int i = 1; i <= 10; i++) begin
      send_vote(0, 10, 0);
      if (i == 5) check("sat_pos_at5", sum_of(0), 50);
    end
    check("sat_pos_hold", sum_of(0), 50);
    send_vote(2, -127, 0);
    check("sat_neg_first", sum_of(2), -50);
    send_vote(2, -127, 0);
    send_vote(2, -127, 0);
    check("sat_neg_nowrap", sum_of(2), -50);
    send_vote(0, -127, 1);
    check_sums("sat", -50, 0, -50, 0, 0);
    wait_pred(lat);
    check("sat_latency", lat, NC);
    check("sat_pred_class", pred_class, 1);
    check("sat_pred_sum", pred_sum, 0);
    pred_ready = 1'b1;
    tick();
    pred_ready = 1'b0;

    // Ties, out-of-range class, stall in ARGMAX, held prediction
    do_start();
    send_vote(1, 20, 0);
    send_vote(3, 20, 0);
    send_vote(0, 5, 0);
    send_vote(2, 5, 0);
    vote_valid = 1'b1; vote_class = 3'd7; vote_in = 8'sd50; vote_last = 1'b1;
    #1;
    check("inval_vote_ready", vote_ready, 1);
    tick();
    vote_valid = 1'b0; vote_last = 1'b0;
    check_sums("tie", 5, 20, 5, 20, 0);
    check("tie_busy", busy, 1);
    tick();
    stop_flag = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_no_pred", pred_valid, 0);
    end
    stop_flag = 1'b0;
    wait_pred(lat);
    check("stall_latency", lat + 4, NC + 3);
    check("tie_pred_class", pred_class, 1);
    check("tie_pred_sum", pred_sum, 20);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("hold_valid", pred_valid, 1);
      check("hold_class", pred_class, 1);
      check("hold_sum", pred_sum, 20);
    end
    stop_flag = 1'b1; pred_ready = 1'b1;
    tick();
    check("stop_blocks_ready", pred_valid, 1);
    stop_flag = 1'b0;
    tick();
    pred_ready = 1'b0;
    check("tie_consumed", pred_valid, 0);
    check("tie_idle_busy", busy, 0);
    check("tie_sum_keep", sum_of(3), 20);

    // Restart mid-accumulation
    do_start();
    send_vote(0, 10, 0);
    send_vote(1, 5, 0);
    start = 1'b1; vote_valid = 1'b1; vote_class = 3'd3; vote_in = 8'sd40;
    #1;
    check("restart_vote_ready", vote_ready, 0);
    tick();
    start = 1'b0; vote_valid = 1'b0;
    check("restart_cleared", |class_sum_out, 0);
    send_vote(3, 7, 0);
    send_vote(4, 9, 1);
    check_sums("restart", 0, 0, 0, 7, 9);
    wait_pred(lat);
    check("restart_latency", lat, NC);
    check("restart_pred_class", pred_class, 4);
    check("restart_pred_sum", pred_sum, 9);
    pred_ready = 1'b1;
    tick();
    pred_ready = 1'b0;

    // Asynchronous reset mid-ACCUM
    do_start();
    send_vote(2, 30, 0);
    check("pre_rst_sum", sum_of(2), 30);
    #2;
    rst_flag = 1'b1;
    #1;
    check("arst_sums", |class_sum_out, 0);
    check("arst_busy", busy, 0);
    check("arst_vote_ready", vote_ready, 0);
    check("arst_pred_valid", pred_valid, 0);
    tick();
    rst_flag = 1'b0;
    vote_valid = 1'b1; vote_class = 3'd2; vote_in = 8'sd11;
    #1;
    check("post_rst_vote_ready", vote_ready, 0);
    tick();
    vote_valid = 1'b0;
    check("post_rst_sum", sum_of(2), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/class_sum_accum_argmax.md
Name: class_sum_accum_argmax

Overview:
- Parametrised successor to the single-channel class-sum clamp.
- Accepts a stream of signed clause votes tagged with a class index and accumulates them per class.
- Saturates each running sum to ±THRESHOLD, then runs a sequential argmax over all classes and hands the predicted class downstream with a valid/ready handshake.
- Sits between the clause-evaluation array and the inference-result interface.

Parameters:
- N_CLASSES, 4, number of classes; must be ≥2.
- SUM_W, 32, width of each signed class sum.
- VOTE_W, 8, width of each signed incoming vote.
- THRESHOLD, 50, positive clamp bound T; sums are held in [-T, +T]. Static check: 0 < T ≤ 2^(SUM_W-1) - 2^(VOTE_W-1).
- IDX_W, $clog2(N_CLASSES), derived localparam; class index width.

Ports:
- clk  in  1  clock
- rst_flag  in  1  asynchronous active-high reset
- stop_flag  in  1  global freeze; no state changes while high
- start  in  1  single-cycle pulse; clears all sums and begins a new inference
- vote_valid  in  1  vote present
- vote_ready  out  1  vote accepted this cycle when vote_valid is also high
- vote_class  in  IDX_W  target class of the vote
- vote_in  in  VOTE_W  signed vote value
- vote_last  in  1  marks the final vote of this inference
- class_sum_out  out  N_CLASSES*SUM_W  clamped sums, flattened; class k at bits [k*SUM_W +: SUM_W]
- pred_valid  out  1  prediction available
- pred_ready  in  1  downstream accepts the prediction
- pred_class  out  IDX_W  index of the winning class
- pred_sum  out  SUM_W  clamped sum of the winning class
- busy  out  1  high in ACCUM or ARGMAX

Behaviour:
- Reset (async, rst_flag=1): state=IDLE. All sums, pred_class, pred_sum = 0. pred_valid=0, vote_ready=0, busy=0.
- stop_flag=1 freezes every register except under reset:
  - vote_ready forced 0.
  - start and pred_ready are ignored.
  - The argmax does not advance.
  - Outputs hold their values.
- start=1 with stop_flag=0 has top priority in any state: next cycle all sums=0, pred_valid=0, state=ACCUM. A vote coincident with start is not accepted (vote_ready is 0 whenever start=1).
- IDLE: vote_ready=0. Waits for start.
- ACCUM:
  - vote_ready = !stop_flag && !start.
  - On accept, the class selected by vote_class is updated to clamp(sum + sign-extended vote_in, -T, +T). The add is computed at SUM_W+1 bits, so no wrap is possible.
  - The updated value is visible on class_sum_out the next cycle.
  - Only one class is updated per cycle.
  - vote_class ≥ N_CLASSES: vote is accepted and discarded; no sum changes.
  - Accepting a vote with vote_last=1 (after its update) moves the block to ARGMAX next cycle.
- ARGMAX:
  - Scans one class per non-stopped cycle, idx 0..N_CLASSES-1, over N_CLASSES cycles.
  - Idx 0 seeds the best value; a later class replaces it only if strictly greater. Ties therefore go to the lowest index.
  - After the last index: pred_class and pred_sum are registered, pred_valid=1, state=DONE.
- Latency: vote_last accepted in cycle t gives pred_valid high in cycle t+N_CLASSES+1 (no stalls).
- DONE:
  - pred_valid held high and pred_class/pred_sum held stable until pred_ready=1 with stop_flag=0.
  - Next cycle: pred_valid=0, state=IDLE.
  - class_sum_out keeps its final values until the next start.
- pred_ready while pred_valid=0 has no effect.
- Reset mid-operation aborts immediately to reset values; no partial prediction is emitted.

Decomposition:
- Shared package tm_pkg:
  - Default THRESHOLD, SUM_W, VOTE_W constants.
  - State enum (IDLE, ACCUM, ARGMAX, DONE).
  - Signed-sum typedef.
- One natural sub-module, tm_sat_clamp_add: combinational signed add with SUM_W+1-bit intermediate and ±T clamp. It is reusable by the existing single-channel clamp path.

Test Plan:
- Reset: assert rst_flag mid-ACCUM → all outputs 0 asynchronously, state IDLE; votes ignored until the next start.
- Basic: start; votes (c0,+3),(c1,+7),(c2,-4),(c1,+2,last) → class_sum_out = {0,-4,9,3} (classes 3..0); pred_class=1, pred_sum=9, pred_valid exactly N_CLASSES+1 cycles after last.
- Saturation: 10 votes (c0,+10) then (c0,-127,last) with T=50 → sum holds 50 after the 5th vote; final value -77 clamps to -50. Likewise 3×(c2,-127) → -50, never wraps.
- Tie and invalid class: c1=c3=20, c0=c2=5, plus vote to class index 7 with N_CLASSES=4 … use N_CLASSES=8 build with class 9 unrepresentable; instead drive class idx ≥ N → no sum change, vote_ready still 1; pred_class=1 (lowest tie).
- Stall/handshake: stop_flag high for 3 cycles in ARGMAX → prediction delayed exactly 3 cycles, values unchanged. Hold pred_ready=0 for 5 cycles → pred_valid and values stable, then clear the cycle after pred_ready=1.
- Restart: start pulse during ACCUM after partial votes → sums cleared next cycle; coincident vote not accepted; new inference produces the correct result from fresh votes only.
